// File: rtl/rs15_11_enc_core_if.sv
// Stream bundle for the RS(15,11) encoder: message symbols in, codeword symbols out.
// The master side is the producer/consumer environment; the slave side is the encoder.
interface rs15_11_enc_core_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sop, out_eop
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/rs15_11_enc_core.sv
// Systematic RS(15,11) encoder over GF(16) (x^4+x+1), g(x) = x^4 + 13x^3 + 12x^2 + 8x + 7.
// Echoes 11 message symbols, then shifts out the 4 parity symbols (x^3 coefficient first).

module gf16mul #(
  parameter logic [3:0] B = 4'h1
) (
  input  logic [3:0] a,
  output logic [3:0] y
);
  logic [3:0] acc;
  logic [3:0] x;

  // Shift-and-add multiply by a constant; x*alpha reduces with x^4 = x + 1.
  always_comb begin
    acc = 4'h0;
    x   = a;
    for (int i = 0; i < 4; i++) begin
      if (B[i]) acc = acc ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    y = acc;
  end
endmodule

module rs15_11_enc_core #(
  parameter int K    = 11,
  parameter int NPAR = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  rs15_11_enc_core_if.slave   s
);
  typedef enum logic {ST_DATA, ST_PARITY} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic [3:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [3:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;

  logic       adv;
  logic       accept;
  logic [3:0] fb;
  logic [3:0] fb_m13, fb_m12, fb_m8, fb_m7;

  assign adv        = !out_valid_q || s.out_ready;
  assign s.in_ready = rst_n && (state_q == ST_DATA) && adv && !clr;
  assign accept     = s.in_valid && s.in_ready;
  assign fb         = s.in_data ^ r3_q;

  gf16mul #(.B(4'd13)) u_mul13 (.a(fb), .y(fb_m13));
  gf16mul #(.B(4'd12)) u_mul12 (.a(fb), .y(fb_m12));
  gf16mul #(.B(4'd8))  u_mul8  (.a(fb), .y(fb_m8));
  gf16mul #(.B(4'd7))  u_mul7  (.a(fb), .y(fb_m7));

  assign s.out_data  = out_data_q;
  assign s.out_valid = out_valid_q;
  assign s.out_sop   = out_sop_q;
  assign s.out_eop   = out_eop_q;

  // clr outranks everything; otherwise nothing moves unless the output slot is free.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (clr) begin
      state_d     = ST_DATA;
      cnt_d       = 4'd0;
      pcnt_d      = 2'd0;
      r0_d        = 4'h0;
      r1_d        = 4'h0;
      r2_d        = 4'h0;
      r3_d        = 4'h0;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end else if (adv) begin
      if (state_q == ST_DATA) begin
        if (accept) begin
          r3_d        = r2_q ^ fb_m13;
          r2_d        = r1_q ^ fb_m12;
          r1_d        = r0_q ^ fb_m8;
          r0_d        = fb_m7;
          out_data_d  = s.in_data;
          out_valid_d = 1'b1;
          out_sop_d   = (cnt_q == 4'd0);
          out_eop_d   = 1'b0;
          cnt_d       = cnt_q + 4'd1;
          if (cnt_q == 4'(K - 1)) begin
            state_d = ST_PARITY;
            pcnt_d  = 2'd0;
          end
        end else begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
        end
      end else begin
        // Parity drains from r3 downward; zeros fill in behind so the LFSR ends clean.
        out_data_d  = r3_q;
        out_valid_d = 1'b1;
        out_sop_d   = 1'b0;
        out_eop_d   = (pcnt_q == 2'(NPAR - 1));
        r3_d        = r2_q;
        r2_d        = r1_q;
        r1_d        = r0_q;
        r0_d        = 4'h0;
        pcnt_d      = pcnt_q + 2'd1;
        if (pcnt_q == 2'(NPAR - 1)) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DATA;
      cnt_q       <= 4'd0;
      pcnt_q      <= 2'd0;
      r0_q        <= 4'h0;
      r1_q        <= 4'h0;
      r2_q        <= 4'h0;
      r3_q        <= 4'h0;
      out_data_q  <= 4'h0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end
endmodule

// File: tb/tb_rs15_11_enc_core.sv
// Scoreboard bench for rs15_11_enc_core: expected symbols come from a long-division
// parity model, and every finished codeword is also checked for zero syndromes.
module tb_rs15_11_enc_core;
  typedef logic [3:0] msg_t [11];
  typedef struct packed {
    logic [3:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr;

  rs15_11_enc_core_if bus ();

  rs15_11_enc_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .s     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [3:0] cw_buf[$];
  int         cyc = 0;
  int         out_count = 0;
  int         accepted = 0;
  int         first_hs = 0;
  int         last_hs = 0;
  bit         arm_first = 1'b0;
  bit         rand_ready = 1'b0;
  bit         prev_stall = 1'b0;
  exp_t       held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Downstream readiness: always ready, or a coin flip each cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached, got no finish, need finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] x;
    r = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] alpha_pow(input int j);
    logic [3:0] a;
    a = 4'h1;
    for (int i = 0; i < j; i++) a = gmul(a, 4'h2);
    return a;
  endfunction

  // Remainder of m(x)*x^4 divided by g(x); returned as {x^3, x^2, x^1, x^0} coefficients.
  function automatic logic [15:0] calc_par(input msg_t m);
    logic [3:0] rem [15];
    logic [3:0] g [5];
    logic [3:0] coef;
    g[0] = 4'd1; g[1] = 4'd13; g[2] = 4'd12; g[3] = 4'd8; g[4] = 4'd7;
    for (int i = 0; i < 15; i++) rem[i] = (i < 11) ? m[i] : 4'h0;
    for (int i = 0; i < 11; i++) begin
      coef = rem[i];
      for (int j = 0; j < 5; j++) rem[i + j] = rem[i + j] ^ gmul(coef, g[j]);
    end
    return {rem[11], rem[12], rem[13], rem[14]};
  endfunction

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t       e;
    logic [15:0] syn;
    logic [3:0]  s;
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop} !== {1'b1, held}) begin
          errors++;
          $display("[TB] FAIL stall_hold got v=%b d=%h sop=%b eop=%b need v=1 d=%h sop=%b eop=%b",
                   bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, held.d, held.sop, held.eop);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        out_count++;
        last_hs = cyc;
        if (arm_first) begin
          first_hs  = cyc;
          arm_first = 1'b0;
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output got d=%h with empty scoreboard, need no output", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_sop, bus.out_eop} !== e) begin
            errors++;
            $display("[TB] FAIL out_sym got d=%h sop=%b eop=%b need d=%h sop=%b eop=%b",
                     bus.out_data, bus.out_sop, bus.out_eop, e.d, e.sop, e.eop);
          end
        end
        if (bus.out_sop === 1'b1) cw_buf.delete();
        cw_buf.push_back(bus.out_data);
        if (bus.out_eop === 1'b1) begin
          syn = 16'h0;
          for (int j = 1; j <= 4; j++) begin
            s = 4'h0;
            foreach (cw_buf[k]) s = gmul(s, alpha_pow(j)) ^ cw_buf[k];
            syn[(4 - j) * 4 +: 4] = s;
          end
          checks++;
          if (cw_buf.size() != 15 || syn !== 16'h0) begin
            errors++;
            $display("[TB] FAIL syndromes got len=%0d S1..S4=%h need len=15 S=0000", cw_buf.size(), syn);
          end
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      held = '{d: bus.out_data, sop: bus.out_sop, eop: bus.out_eop};
    end
  end

  // Offers the first n symbols of m; a full message also queues its parity.
  task automatic send_msg(input msg_t m, input int n);
    bit          got;
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      bus.in_data  = m[i];
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (bus.in_ready === 1'b1) begin
          got = 1'b1;
          sb.push_back('{d: m[i], sop: (i == 0), eop: 1'b0});
          accepted++;
        end
        @(posedge clk);
        #1;
      end
      checks++;
      if (got !== 1'b1) begin
        errors++;
        $display("[TB] FAIL accept_timeout sym %0d got in_ready=0 need 1", i);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    if (n == 11) begin
      p = calc_par(m);
      for (int k = 0; k < 4; k++)
        sb.push_back('{d: p[(3 - k) * 4 +: 4], sop: 1'b0, eop: (k == 3)});
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got %0d pending symbols need 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rdy=%b v=%b sop=%b eop=%b d=%h need all 0",
               bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL post_reset got rdy=%b v=%b need rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_zero_msg();
    msg_t m;
    foreach (m[i]) m[i] = 4'h0;
    send_msg(m, 11);
    wait_drain();
  endtask

  task automatic test_single_one();
    msg_t m;
    foreach (m[i]) m[i] = 4'h0;
    m[10] = 4'h1;
    send_msg(m, 11);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    msg_t m;
    int   oc0;
    int   acc0;
    oc0  = out_count;
    acc0 = accepted;
    arm_first = 1'b1;
    for (int k = 0; k < 200; k++) begin
      foreach (m[i]) m[i] = 4'($urandom_range(0, 15));
      send_msg(m, 11);
    end
    wait_drain();
    checks++;
    if (out_count - oc0 != 3000 || accepted - acc0 != 2200) begin
      errors++;
      $display("[TB] FAIL b2b_counts got out=%0d in=%0d need out=3000 in=2200", out_count - oc0, accepted - acc0);
    end
    checks++;
    if (last_hs - first_hs + 1 != 3000) begin
      errors++;
      $display("[TB] FAIL b2b_gapless got span=%0d cycles need 3000", last_hs - first_hs + 1);
    end
  endtask

  task automatic test_backpressure();
    msg_t m;
    rand_ready = 1'b1;
    foreach (m[i]) m[i] = 4'h0;
    m[10] = 4'h1;
    send_msg(m, 11);
    foreach (m[i]) m[i] = 4'($urandom_range(0, 15));
    send_msg(m, 11);
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clr();
    msg_t m;
    foreach (m[i]) m[i] = 4'($urandom_range(1, 15));
    send_msg(m, 6);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_ready got in_ready=%b need 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    checks++;
    if ({bus.out_valid, bus.out_sop, bus.out_eop} !== 3'b000 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL clr_flush got v=%b sop=%b eop=%b pending=%0d need 0 0 0 0",
               bus.out_valid, bus.out_sop, bus.out_eop, sb.size());
    end
    foreach (m[i]) m[i] = 4'h0;
    m[10] = 4'h1;
    send_msg(m, 11);
    wait_drain();
  endtask

  task automatic test_reset_mid_parity();
    msg_t m;
    foreach (m[i]) m[i] = 4'($urandom_range(0, 15));
    send_msg(m, 11);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset got rdy=%b v=%b sop=%b eop=%b d=%h need all 0",
               bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data);
    end
    sb.delete();
    cw_buf.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (m[i]) m[i] = 4'($urandom_range(0, 15));
    send_msg(m, 11);
    wait_drain();
  endtask

  initial begin
    rst_n        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    test_reset();
    test_zero_msg();
    test_single_one();
    test_back_to_back();
    test_backpressure();
    test_clr();
    test_reset_mid_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
